// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - byte holding-register handshake and error pulses of uart_rx
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, parity_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with single-entry valid/ready holding register
// Define UART_RX_PARITY_EN for 8E1 framing with parity_err reporting.
module uart_rx #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD_RATE  = 115200,
  parameter int BIT_PERIOD = CLK_FREQ / BAUD_RATE
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx,
  uart_rx_if.master rx_if
);

  localparam int          HALF_PERIOD = BIT_PERIOD / 2;
  localparam logic [15:0] BIT_LAST    = 16'(BIT_PERIOD - 1);
  localparam logic [15:0] HALF_LAST   = 16'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        rx_meta, rx_s;
  logic        stop_ok, stop_bad;
  logic        cnt_wrap;

  logic [7:0]  data_q;
  logic        valid_q;
  logic        frame_err_q;
  logic        overrun_q;
  logic        parity_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign cnt_wrap = (cnt_q == BIT_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Mid-start recheck rejects short low glitches.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = 16'd0;
          idx_d   = 3'd0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_wrap) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = 16'd0;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_wrap) begin
          par_d   = rx_s;
          cnt_d   = 16'd0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      STOP: begin
        // Leaving at mid-stop lets a back-to-back start edge be caught.
        if (cnt_wrap) begin
          cnt_d = 16'd0;
          if (rx_s) begin
            stop_ok = 1'b1;
            state_d = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= 8'd0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      frame_err_q  <= stop_bad;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= stop_ok && (^{shift_q, par_q});
`else
      parity_err_q <= 1'b0;
`endif
      if (stop_ok) begin
        if (!valid_q || rx_if.rx_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && rx_if.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.overrun    = overrun_q;
  assign rx_if.parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with random frames and baud skew
module tb_uart_rx;
  localparam int BIT  = 234;
  localparam int HALF = 117;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NBITS   = 9 + int'(PAR_EN);
  localparam int EXP_LAT = 3 + HALF + NBITS * BIT;
  localparam int F_FE = 1, F_OV = 2, F_PE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  logic [7:0] exp_bytes[$];
  int         exp_flags[$];

  uart_rx_if u_if ();

  uart_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_if (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pop_flag(input string name, input int kind);
    if (exp_flags.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s actual=pulse required=none", name);
    end else begin
      chk(name, kind, exp_flags.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.frame_err)  pop_flag("frame_err", F_FE);
      if (u_if.overrun)    pop_flag("overrun", F_OV);
      if (u_if.parity_err) pop_flag("parity_err", F_PE);
      if (u_if.rx_valid && u_if.rx_ready) begin
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_data actual=%0h required=none", u_if.rx_data);
        end else begin
          chk("rx_data", int'(u_if.rx_data), int'(exp_bytes.pop_front()));
        end
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected outcome of one frame, from the line-protocol rules alone.
  task automatic model(input logic [7:0] d, input logic stop, input logic pflip);
    if (!stop) begin
      exp_flags.push_back(F_FE);
    end else begin
      exp_bytes.push_back(d);
      if (PAR_EN && pflip) exp_flags.push_back(F_PE);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip, input int per);
    rx = 1'b0;
    hold(per);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold(per);
    end
    if (PAR_EN) begin
      rx = (^d) ^ pflip;
      hold(per);
    end
    rx = stop;
    hold(per);
  endtask

  task automatic wait_valid();
    int lat;
    lat = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (u_if.rx_valid) begin
        lat = cyc - start_cyc;
        break;
      end
    end
    checks++;
    if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin
      errors++;
      $display("FAIL latency actual=%0d required=%0d", lat, EXP_LAT);
    end
    @(negedge clk);
    chk("valid_cleared", int'(u_if.rx_valid), 0);
  endtask

  task automatic chk_outputs_zero();
    chk("rst_rx_data", int'(u_if.rx_data), 0);
    chk("rst_rx_valid", int'(u_if.rx_valid), 0);
    chk("rst_frame_err", int'(u_if.frame_err), 0);
    chk("rst_overrun", int'(u_if.overrun), 0);
    chk("rst_parity_err", int'(u_if.parity_err), 0);
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       pflip;
    int         per;

    u_if.rx_ready = 1'b1;
    hold(5);
    chk_outputs_zero();
    rst_n = 1'b1;
    hold(10);

    model(8'h41, 1'b1, 1'b0);
    start_cyc = cyc;
    fork
      send_frame(8'h41, 1'b1, 1'b0, BIT);
      wait_valid();
    join

    rx = 1'b0;
    hold(50);
    rx = 1'b1;
    hold(300);
    model(8'h55, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0, BIT);

    model(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, BIT);
    hold(2000);
    rx = 1'b1;
    hold(BIT);
    model(8'hA5, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, BIT);

    u_if.rx_ready = 1'b0;
    exp_bytes.push_back(8'h12);
    exp_flags.push_back(F_OV);
    send_frame(8'h12, 1'b1, 1'b0, BIT);
    send_frame(8'h34, 1'b1, 1'b0, BIT);
    hold(50);
    chk("held_valid", int'(u_if.rx_valid), 1);
    chk("held_data", int'(u_if.rx_data), 8'h12);
    u_if.rx_ready = 1'b1;
    hold(5);

    model(8'h12, 1'b1, 1'b0);
    model(8'h34, 1'b1, 1'b0);
    send_frame(8'h12, 1'b1, 1'b0, BIT);
    send_frame(8'h34, 1'b1, 1'b0, BIT);
    hold(50);

    // Abort an 0xFF frame in the middle of data bit 4.
    rx = 1'b0;
    hold(BIT);
    rx = 1'b1;
    hold(4 * BIT + BIT / 2);
    rst_n = 1'b0;
    hold(3);
    chk_outputs_zero();
    hold(20);
    rst_n = 1'b1;
    hold(2 * BIT);
    model(8'h81, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0, BIT);

`ifdef UART_RX_PARITY_EN
    model(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1, BIT);
    model(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, BIT);
`endif

    // Random bytes at up to +/-4% baud skew, occasional framing errors.
    for (int n = 0; n < 12; n++) begin
      d     = 8'($urandom);
      per   = $urandom_range(225, 243);
      stop  = ($urandom_range(0, 7) != 0);
      pflip = PAR_EN && stop && ($urandom_range(0, 1) == 1);
      model(d, stop, pflip);
      send_frame(d, stop, pflip, per);
      if (!stop) begin
        rx = 1'b1;
        hold(2 * per);
      end else if ($urandom_range(0, 1) == 1) begin
        hold($urandom_range(1, per));
      end
    end

    hold(300);
    chk("bytes_pending", exp_bytes.size(), 0);
    chk("flags_pending", exp_flags.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
